coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter MAX_TOTAL, default 200, SHALL set the saturation ceiling for the accumulated credit.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 coin_valid  input  1  SHALL be a single-cycle pulse marking an inserted coin.
REQ-005 coin_type  input  2  SHALL encode the denomination: 00=1, 01=5, 10=10, 11=50.
REQ-006 deduct_valid  input  1  SHALL be a single-cycle pulse from the downstream vending FSM requesting a purchase charge.
REQ-007 deduct_amount  input  8  SHALL carry the price to charge, qualified by deduct_valid.
REQ-008 refund_req  input  1  SHALL be a single-cycle pulse requesting return of all credit.
REQ-009 change_ack  input  1  SHALL be the dispenser's acknowledgement that the change has been paid out.
REQ-010 total_coin  output  8  SHALL give the current accumulated credit, feeding the vending FSM.
REQ-011 ready  output  1  SHALL be high when coins and deducts can be accepted.
REQ-012 coin_reject  output  1  SHALL pulse for one cycle when a coin is refused.
REQ-013 deduct_ok / deduct_err  output  1 each  SHALL pulse for one cycle to report the deduct result.
REQ-014 change_valid  output  1  SHALL be high while a refund is offered to the dispenser.
REQ-015 change_amount  output  8  SHALL hold the refund value while change_valid is high.

Function
REQ-016 States SHALL be IDLE (total_coin==0), ACCUM (total_coin>0) and REFUND.
REQ-017 ready SHALL equal 1 in IDLE/ACCUM and 0 in REFUND.
REQ-018 Coin value and state changes SHALL apply as follows.
- Condition: coin_valid in IDLE/ACCUM and total_coin+value <= MAX_TOTAL.
- Action: total_coin += value on the next edge.
- State: move to ACCUM.
REQ-019 A coin SHALL be rejected in each of these cases.
- Cases: the coin would exceed MAX_TOTAL, it arrives in REFUND, or deduct_valid is high in the same cycle.
- Action: coin_reject is 1 for exactly the following cycle; total_coin is unchanged.
REQ-020 deduct_valid in IDLE/ACCUM with deduct_amount <= total_coin SHALL subtract the amount next cycle and pulse deduct_ok.
- New state: IDLE if the result is 0, otherwise ACCUM.
REQ-021 deduct_valid with deduct_amount > total_coin, or in REFUND, SHALL pulse deduct_err and leave total_coin unchanged.
REQ-022 Priority in one cycle SHALL be refund_req > deduct_valid > coin_valid.
- A lower-priority event that loses is reported as coin_reject or deduct_err.
REQ-023 refund_req in ACCUM SHALL enter REFUND next cycle.
- Outputs: change_valid=1 and change_amount=total_coin.
REQ-024 refund_req in IDLE SHALL be ignored, with no output pulse.
REQ-025 In REFUND, change_valid and change_amount SHALL stay stable until change_ack is sampled high.
REQ-026 change_ack SHALL complete the refund.
- Action: total_coin=0 and change_valid=0 on the next edge.
- State: return to IDLE.
REQ-027 change_ack outside REFUND SHALL be ignored.
REQ-028 Arithmetic SHALL be 9-bit internally, so the range check cannot wrap; total_coin never exceeds MAX_TOTAL.
REQ-029 All result pulses SHALL appear exactly one cycle after the triggering input: single latency, no bubbles.
REQ-030 Back-to-back coin_valid pulses on consecutive cycles SHALL each be evaluated against the already-updated total.

Reset
REQ-031 reset=0 at a rising edge SHALL produce these values.
- State: IDLE.
- Outputs: total_coin=0, coin_reject=0, deduct_ok=0, deduct_err=0, change_valid=0, change_amount=0.
- ready: 1 from the first cycle after reset is released.
REQ-032 reset asserted mid-REFUND SHALL drop change_valid on that edge and discard the credit, with no ack required.
REQ-033 Inputs sampled while reset=0 SHALL have no effect.

Structure
REQ-034 The shared package vend_pkg SHALL hold the following.
- Denomination constants: COIN_1, COIN_5, COIN_10, COIN_50.
- The coin_type encoding.
- The acceptor state encoding.
REQ-035 The type-to-value mapping SHALL be a combinational sub-module coin_decode (coin_type -> 8-bit value).
REQ-036 State register and next-state logic SHALL be separate processes; the credit register is updated only in the sequential process.

Verification
REQ-037 Accumulation: coins 10, 50, 5, 1 on consecutive cycles -> total_coin 10, 60, 65, 66; ready stays 1; no reject.
REQ-038 Saturation: total_coin=190 plus a coin of 50 -> coin_reject pulse; total stays 190. A following coin of 10 -> total 200.
REQ-039 Deduct: total 66, deduct 25 -> deduct_ok, total 41. Then deduct 50 -> deduct_err, total 41. Then deduct 41 -> total 0, state IDLE.
REQ-040 Collision: coin 10 and deduct 5 in the same cycle with total 20 -> total 15, deduct_ok and coin_reject both pulse.
REQ-041 Refund handshake: total 35, refund_req -> change_valid=1, change_amount=35.
- Hold change_ack low for 3 cycles -> outputs stable; a coin of 5 in this window is rejected.
- Then change_ack -> total 0, IDLE.
REQ-042 Reset mid-refund: in REFUND with 35 pending, reset=0 for one edge -> change_valid=0, total 0, ready=1 after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin denominations, coin_type encoding and
// the acceptor state encoding.
package vend_pkg;

    // Credit value of each denomination
    localparam logic [7:0] COIN_1  = 8'd1;
    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_50 = 8'd50;

    // Two-bit denomination code carried on coin_type
    typedef enum logic [1:0] {
        COIN_TYPE_1  = 2'b00,
        COIN_TYPE_5  = 2'b01,
        COIN_TYPE_10 = 2'b10,
        COIN_TYPE_50 = 2'b11
    } coin_type_t;

    // Acceptor states; IDLE means no credit, ACCUM means credit held
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_REFUND = 2'd2;

endpackage

// File: rtl/coin_acceptor_if.sv
// Bundle of coin, purchase-charge and change-dispense signals shared by the
// acceptor (slave) and the surrounding vending logic (master).
interface coin_acceptor_if;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       deduct_valid;
    logic [7:0] deduct_amount;
    logic       refund_req;
    logic       change_ack;
    logic [7:0] total_coin;
    logic       ready;
    logic       coin_reject;
    logic       deduct_ok;
    logic       deduct_err;
    logic       change_valid;
    logic [7:0] change_amount;

    modport master (
        output coin_valid, coin_type, deduct_valid, deduct_amount,
               refund_req, change_ack,
        input  total_coin, ready, coin_reject, deduct_ok, deduct_err,
               change_valid, change_amount
    );

    modport slave (
        input  coin_valid, coin_type, deduct_valid, deduct_amount,
               refund_req, change_ack,
        output total_coin, ready, coin_reject, deduct_ok, deduct_err,
               change_valid, change_amount
    );
endinterface

// File: rtl/coin_decode.sv
// Combinational map from coin_type code to credit value.
module coin_decode
    import vend_pkg::*;
(
    input  logic [1:0] coin_type,
    output logic [7:0] value
);

    // Denomination lookup
    always_comb begin
        value = COIN_1;
        case (coin_type_t'(coin_type))
            COIN_TYPE_1:  value = COIN_1;
            COIN_TYPE_5:  value = COIN_5;
            COIN_TYPE_10: value = COIN_10;
            COIN_TYPE_50: value = COIN_50;
            default:      value = COIN_1;
        endcase
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: accumulates credit up to MAX_TOTAL, applies purchase charges,
// and runs a refund handshake with the change dispenser. All result pulses are
// registered and appear one cycle after the triggering input.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int MAX_TOTAL = 200
) (
    input  logic            clk,
    input  logic            reset,
    coin_acceptor_if.slave  bus
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] total;
    logic [7:0] total_next;
    logic [7:0] coin_value;
    logic       reject_next;
    logic       ok_next;
    logic       err_next;
    logic       coin_reject_q;
    logic       deduct_ok_q;
    logic       deduct_err_q;

    // Nine-bit sum so a large total plus a coin cannot wrap past the ceiling
    function automatic logic fits_credit(input logic [7:0] cur, input logic [7:0] add);
        logic [8:0] sum;
        sum = {1'b0, cur} + {1'b0, add};
        return (sum <= 9'(MAX_TOTAL));
    endfunction

    coin_decode u_decode (
        .coin_type (bus.coin_type),
        .value     (coin_value)
    );

    // Next-state, next-credit and result-pulse decision for this cycle
    always_comb begin
        state_next  = state;
        total_next  = total;
        reject_next = 1'b0;
        ok_next     = 1'b0;
        err_next    = 1'b0;
        if (state == ST_REFUND) begin
            // Credit is frozen while the dispenser is paying out
            reject_next = bus.coin_valid;
            err_next    = bus.deduct_valid;
            if (bus.change_ack) begin
                total_next = 8'd0;
                state_next = ST_IDLE;
            end
        end else if (bus.refund_req && (state == ST_ACCUM)) begin
            // Refund outranks everything; losers are reported back
            state_next  = ST_REFUND;
            reject_next = bus.coin_valid;
            err_next    = bus.deduct_valid;
        end else begin
            if (bus.deduct_valid) begin
                reject_next = bus.coin_valid;
                if (bus.deduct_amount <= total) begin
                    total_next = total - bus.deduct_amount;
                    ok_next    = 1'b1;
                end else begin
                    err_next   = 1'b1;
                end
            end else if (bus.coin_valid) begin
                if (fits_credit(total, coin_value)) begin
                    total_next = total + coin_value;
                end else begin
                    reject_next = 1'b1;
                end
            end
            state_next = (total_next == 8'd0) ? ST_IDLE : ST_ACCUM;
        end
    end

    // State, credit and result-pulse registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            total         <= 8'd0;
            coin_reject_q <= 1'b0;
            deduct_ok_q   <= 1'b0;
            deduct_err_q  <= 1'b0;
        end else begin
            state         <= state_next;
            total         <= total_next;
            coin_reject_q <= reject_next;
            deduct_ok_q   <= ok_next;
            deduct_err_q  <= err_next;
        end
    end

    assign bus.total_coin    = total;
    assign bus.ready         = (state != ST_REFUND);
    assign bus.coin_reject   = coin_reject_q;
    assign bus.deduct_ok     = deduct_ok_q;
    assign bus.deduct_err    = deduct_err_q;
    assign bus.change_valid  = (state == ST_REFUND);
    assign bus.change_amount = (state == ST_REFUND) ? total : 8'd0;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a credit-ledger model.
module tb_coin_acceptor;

    localparam int MAX = 200;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    // Ledger model: credit held and whether a refund is outstanding
    int   m_total  = 0;
    bit   m_refund = 0;
    bit   e_rej, e_ok, e_err;
    int   coin_val [4] = '{1, 5, 10, 50};

    coin_acceptor_if bus_if ();

    coin_acceptor #(.MAX_TOTAL(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the ledger, then compare all outputs
    task automatic step(input bit rst_n, input bit cv, input int ct, input bit dv,
                        input int amt, input bit rr, input bit ack);
        @(negedge clk);
        reset                = rst_n;
        bus_if.coin_valid    = cv;
        bus_if.coin_type     = 2'(ct);
        bus_if.deduct_valid  = dv;
        bus_if.deduct_amount = 8'(amt);
        bus_if.refund_req    = rr;
        bus_if.change_ack    = ack;
        e_rej = 0; e_ok = 0; e_err = 0;
        if (!rst_n) begin
            m_total  = 0;
            m_refund = 0;
        end else if (m_refund) begin
            e_rej = cv;
            e_err = dv;
            if (ack) begin
                m_total  = 0;
                m_refund = 0;
            end
        end else if (rr && m_total > 0) begin
            m_refund = 1;
            e_rej    = cv;
            e_err    = dv;
        end else if (dv) begin
            e_rej = cv;
            if ((amt & 255) <= m_total) begin
                m_total -= (amt & 255);
                e_ok = 1;
            end else begin
                e_err = 1;
            end
        end else if (cv) begin
            if (m_total + coin_val[ct & 3] <= MAX) m_total += coin_val[ct & 3];
            else e_rej = 1;
        end
        @(posedge clk);
        #1;
        chk("total_coin",    int'(bus_if.total_coin),    m_total);
        chk("ready",         int'(bus_if.ready),         int'(!m_refund));
        chk("coin_reject",   int'(bus_if.coin_reject),   int'(e_rej));
        chk("deduct_ok",     int'(bus_if.deduct_ok),     int'(e_ok));
        chk("deduct_err",    int'(bus_if.deduct_err),    int'(e_err));
        chk("change_valid",  int'(bus_if.change_valid),  int'(m_refund));
        chk("change_amount", int'(bus_if.change_amount), m_refund ? m_total : 0);
    endtask

    task automatic idle();                     step(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic coin(input int ct);         step(1, 1, ct, 0, 0, 0, 0); endtask
    task automatic deduct(input int amt);      step(1, 0, 0, 1, amt, 0, 0); endtask
    task automatic refund();                   step(1, 0, 0, 0, 0, 1, 0); endtask
    task automatic ack();                      step(1, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        reset                = 1'b0;
        bus_if.coin_valid    = 1'b0;
        bus_if.coin_type     = 2'd0;
        bus_if.deduct_valid  = 1'b0;
        bus_if.deduct_amount = 8'd0;
        bus_if.refund_req    = 1'b0;
        bus_if.change_ack    = 1'b0;

        // Reset, with a coin presented while held to show it is ignored
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0);
        chk("rst_total", int'(bus_if.total_coin), 0);
        chk("rst_change_valid", int'(bus_if.change_valid), 0);
        chk("rst_change_amount", int'(bus_if.change_amount), 0);
        idle();
        chk("rst_ready", int'(bus_if.ready), 1);

        // Refund with no credit does nothing
        refund();
        chk("idle_refund_cv", int'(bus_if.change_valid), 0);

        // Accumulation 10, 50, 5, 1
        coin(2); chk("acc_10", int'(bus_if.total_coin), 10);
        coin(3); chk("acc_60", int'(bus_if.total_coin), 60);
        coin(1); chk("acc_65", int'(bus_if.total_coin), 65);
        coin(0); chk("acc_66", int'(bus_if.total_coin), 66);
        chk("acc_ready", int'(bus_if.ready), 1);

        // Deducts: ok, error, exact to zero
        deduct(25); chk("ded_ok", int'(bus_if.deduct_ok), 1);
        chk("ded_41", int'(bus_if.total_coin), 41);
        deduct(50); chk("ded_err", int'(bus_if.deduct_err), 1);
        chk("ded_keep41", int'(bus_if.total_coin), 41);
        deduct(41); chk("ded_zero", int'(bus_if.total_coin), 0);

        // Saturation at the ceiling
        coin(3); coin(3); coin(3); coin(2); coin(2); coin(2); coin(2);
        chk("sat_190", int'(bus_if.total_coin), 190);
        coin(3); chk("sat_reject", int'(bus_if.coin_reject), 1);
        chk("sat_keep190", int'(bus_if.total_coin), 190);
        coin(2); chk("sat_200", int'(bus_if.total_coin), 200);
        refund(); chk("sat_refund_amt", int'(bus_if.change_amount), 200);
        ack();    chk("sat_cleared", int'(bus_if.total_coin), 0);

        // Coin and deduct in the same cycle
        coin(2); coin(2);
        step(1, 1, 2, 1, 5, 0, 0);
        chk("col_total", int'(bus_if.total_coin), 15);
        chk("col_ok", int'(bus_if.deduct_ok), 1);
        chk("col_reject", int'(bus_if.coin_reject), 1);

        // Refund handshake with delayed ack
        coin(2); coin(2);
        refund();
        chk("ref_cv", int'(bus_if.change_valid), 1);
        chk("ref_amt", int'(bus_if.change_amount), 35);
        idle(); idle();
        coin(1);
        chk("ref_coin_rej", int'(bus_if.coin_reject), 1);
        chk("ref_hold_amt", int'(bus_if.change_amount), 35);
        ack();
        chk("ref_done_total", int'(bus_if.total_coin), 0);
        chk("ref_done_ready", int'(bus_if.ready), 1);

        // Reset while a refund is pending
        coin(2); coin(2); coin(2); coin(1);
        refund();
        chk("rr_pending", int'(bus_if.change_amount), 35);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rr_cv", int'(bus_if.change_valid), 0);
        chk("rr_total", int'(bus_if.total_coin), 0);
        idle();
        chk("rr_ready", int'(bus_if.ready), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_cv, r_dv, r_rr, r_ack;
            int r_amt;
            r_rst = ($urandom_range(0, 399) != 0);
            r_cv  = ($urandom_range(0, 99) < 50);
            r_dv  = ($urandom_range(0, 99) < 15);
            r_rr  = ($urandom_range(0, 99) < 4);
            r_ack = ($urandom_range(0, 99) < 25);
            r_amt = int'($urandom_range(0, m_total + 20));
            if (r_amt > 255) r_amt = 255;
            step(r_rst, r_cv, int'($urandom_range(0, 3)), r_dv, r_amt, r_rr, r_ack);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
